// File: rtl/pwm_duty_meter.sv
// Measures an incoming pulse train: period, high time and stuck-high/low detection.
// Optional duty-cycle divider is built when PWM_METER_DUTY_EN is defined.
module pwm_duty_meter #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 20_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic [6:0]       duty_pct,
  output logic             duty_valid,
  output logic             busy,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   in_s;
  logic                   rise_c;

  assign in_s   = sync_q[SYNC_STAGES-1];
  assign rise_c = in_s & ~sync_d;

  // Input synchronizer plus one-flop edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      sync_d <= in_s;
    end
  end

  logic [CNT_W-1:0] p_cnt;
  logic [CNT_W-1:0] h_cnt;

  // Cycles since last rise (saturating) and high cycles since last rise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_cnt <= '0;
      h_cnt <= '0;
    end else if (rise_c) begin
      p_cnt <= '0;
      h_cnt <= CNT_W'(1);
    end else begin
      if (p_cnt != P_MAX) p_cnt <= p_cnt + CNT_W'(1);
      if (in_s && (h_cnt != '1)) h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  typedef enum logic {IDLE, ARMED} state_t;
  state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise_c) begin
            state    <= ARMED;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
          end
        end
        ARMED: begin
          if (rise_c) begin
            period     <= p_cnt + CNT_W'(1);
            high_time  <= h_cnt;
            meas_valid <= 1'b1;
          end else if (p_cnt == P_MAX) begin
            state    <= IDLE;
            stuck_hi <= in_s;
            stuck_lo <= ~in_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PWM_METER_DUTY_EN
  localparam int unsigned N_W = CNT_W + 7;
  localparam int unsigned I_W = $clog2(N_W + 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(N_W - 1);

  typedef enum logic {DIV_IDLE, DIV_RUN} div_state_t;
  div_state_t div_state;

  logic [N_W-1:0]   num_q;
  logic [N_W-2:0]   quo_q;
  logic [CNT_W-1:0] den_q;
  logic [CNT_W:0]   rem_q;
  logic [I_W-1:0]   iter_q;

  logic             last_c;
  logic             start_c;
  logic [N_W-1:0]   num_new_c;
  logic [CNT_W+1:0] sh0_c;
  logic             ge0_c;
  logic [CNT_W:0]   rem0_c;
  logic [CNT_W+1:0] sh_c;
  logic             ge_c;
  logic [CNT_W:0]   rem_step_c;
  logic [N_W-1:0]   quo_step_c;

  assign last_c  = (div_state == DIV_RUN) && (iter_q == I_LAST);
  assign start_c = meas_valid && ((div_state == DIV_IDLE) || last_c);

  // First restoring step runs on the capture edge so the result lands N_W cycles later
  assign num_new_c = N_W'(high_time) * N_W'(100);
  assign sh0_c     = {{(CNT_W+1){1'b0}}, num_new_c[N_W-1]};
  assign ge0_c     = sh0_c >= {2'b00, period};
  assign rem0_c    = ge0_c ? (sh0_c[CNT_W:0] - {1'b0, period}) : sh0_c[CNT_W:0];

  assign sh_c       = {rem_q, num_q[N_W-1]};
  assign ge_c       = sh_c >= {2'b00, den_q};
  assign rem_step_c = ge_c ? (sh_c[CNT_W:0] - {1'b0, den_q}) : sh_c[CNT_W:0];
  assign quo_step_c = {quo_q, ge_c};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_state  <= DIV_IDLE;
      num_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      iter_q     <= '0;
      duty_pct   <= '0;
      duty_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (last_c) begin
        duty_valid <= 1'b1;
        duty_pct   <= (quo_step_c > N_W'(100)) ? 7'd100 : quo_step_c[6:0];
      end
      if (start_c) begin
        div_state <= DIV_RUN;
        busy      <= 1'b1;
        num_q     <= {num_new_c[N_W-2:0], 1'b0};
        den_q     <= period;
        rem_q     <= rem0_c;
        quo_q     <= {{(N_W-2){1'b0}}, ge0_c};
        iter_q    <= I_W'(1);
      end else if (div_state == DIV_RUN) begin
        num_q  <= {num_q[N_W-2:0], 1'b0};
        rem_q  <= rem_step_c;
        quo_q  <= quo_step_c[N_W-2:0];
        iter_q <= iter_q + I_W'(1);
        if (last_c) begin
          div_state <= DIV_IDLE;
          busy      <= 1'b0;
        end
      end
    end
  end
`else
  assign duty_pct   = '0;
  assign duty_valid = 1'b0;
  assign busy       = 1'b0;
`endif

endmodule
